// File: rtl/rr_arb_pkg.sv
// Shared types, default sizes and helpers for the round-robin arbiter.
package rr_arb_pkg;

   localparam int unsigned N_DEF        = 8;
   localparam int unsigned IDX_W_DEF    = 3;
   localparam int unsigned MAX_HOLD_DEF = 16;
   localparam int unsigned HOLD_W_DEF   = 8;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // One-hot (or zero) vector of up to 8 bits to binary index; zero maps to 0.
   function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) idx = idx | 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter8_prio_enc.sv
// Rotating priority encoder: first set request searching from base+1 upward, wrapping modulo N.
module rr_prio_enc
   import rr_arb_pkg::*;
#(
   parameter int unsigned N     = N_DEF,
   parameter int unsigned IDX_W = IDX_W_DEF
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] base,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   int unsigned pos;

   // Walking the rotated order keeps the lowest rotated index as winner.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = 0;
      for (int unsigned k = 0; k < N; k++) begin
         pos = (32'(base) + 32'd1 + k) % N;
         if (!found && req[IDX_W'(pos)]) begin
            found = 1'b1;
            idx   = IDX_W'(pos);
         end
      end
   end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter with registered one-hot grant, grant hold while requested,
// and forced re-arbitration after MAX_HOLD consecutive cycles.
module rr_arbiter8
   import rr_arb_pkg::*;
#(
   parameter int unsigned N        = N_DEF,
   parameter int unsigned IDX_W    = IDX_W_DEF,
   parameter int unsigned MAX_HOLD = MAX_HOLD_DEF,
   parameter int unsigned HOLD_W   = HOLD_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     req,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid,
   output logic             timeout
);

   localparam logic [N-1:0]      ONE      = N'(1);
   localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);
   localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(N - 1);

   state_t            state;
   logic [IDX_W-1:0]  last;
   logic [HOLD_W-1:0] cnt;
   logic [IDX_W-1:0]  holder;
   logic              holder_req;
   logic [IDX_W-1:0]  base;
   logic              found;
   logic [IDX_W-1:0]  win;

   // While busy the holder is the search base, so it ranks last and is only
   // re-granted on timeout when nobody else is asking.
   assign holder     = IDX_W'(onehot_to_idx(8'(grant)));
   assign holder_req = |(req & grant);
   assign base       = (state == BUSY) ? holder : last;

   rr_prio_enc #(.N(N), .IDX_W(IDX_W)) u_enc (
      .req   (req),
      .base  (base),
      .found (found),
      .idx   (win)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         last        <= LAST_RST;
         cnt         <= '0;
         grant       <= '0;
         grant_idx   <= '0;
         grant_valid <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  state       <= BUSY;
                  cnt         <= '0;
                  grant       <= ONE << win;
                  grant_idx   <= win;
                  grant_valid <= 1'b1;
               end
            end
            BUSY: begin
               if (holder_req && (cnt < HOLD_LIM)) begin
                  cnt <= cnt + HOLD_W'(1);
               end else begin
                  // Release or timeout: rotate past the holder.
                  last    <= holder;
                  timeout <= holder_req;
                  cnt     <= '0;
                  if (found) begin
                     grant       <= ONE << win;
                     grant_idx   <= win;
                     grant_valid <= 1'b1;
                  end else begin
                     state       <= IDLE;
                     grant       <= '0;
                     grant_idx   <= '0;
                     grant_valid <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8 (MAX_HOLD=4): vector table plus scoreboard queue.
module tb_rr_arbiter8;

   typedef struct {
      logic       rst;
      logic [7:0] req;
      logic [7:0] exp_grant;
      logic       exp_timeout;
   } vec_t;

   logic       clk;
   logic       reset;
   logic [7:0] req;
   logic [7:0] grant;
   logic [2:0] grant_idx;
   logic       grant_valid;
   logic       timeout;

   vec_t vecs[$];
   vec_t sb[$];
   int   n_checks;
   int   n_pass;

   rr_arbiter8 #(.N(8), .IDX_W(3), .MAX_HOLD(4), .HOLD_W(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .timeout     (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] exp_idx(input logic [7:0] g);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < 8; i++) if (g[i]) r = 3'(i);
      return r;
   endfunction

   function automatic void add(input logic r, input logic [7:0] q, input logic [7:0] g,
                               input logic t);
      vec_t v;
      v.rst = r; v.req = q; v.exp_grant = g; v.exp_timeout = t;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input int step, input logic [7:0] act,
                        input logic [7:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s step %0d: got %0h, expected %0h", name, step, act, exp);
   endtask

   // Drive one cycle of stimulus, queue its expectation, compare after the edge.
   task automatic apply(input int step, input vec_t v);
      vec_t e;
      @(negedge clk);
      reset = v.rst;
      req   = v.req;
      sb.push_back(v);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_checks++;
         $display("FAIL scoreboard step %0d: got empty queue, expected entry", step);
      end else begin
         e = sb.pop_front();
         check("grant",       step, grant,              e.exp_grant);
         check("grant_idx",   step, 8'(grant_idx),      8'(exp_idx(e.exp_grant)));
         check("grant_valid", step, 8'(grant_valid),    8'(|e.exp_grant));
         check("timeout",     step, 8'(timeout),        8'(e.exp_timeout));
      end
   endtask

   initial begin
      vec_t v;
      n_checks = 0;
      n_pass   = 0;
      reset    = 1'b1;
      req      = 8'h00;

      // Reset with a request held, then a lone requester times out and is re-granted.
      add(1, 8'h01, 8'h00, 0); add(1, 8'h01, 8'h00, 0);
      add(0, 8'h01, 8'h01, 0); add(0, 8'h01, 8'h01, 0);
      add(0, 8'h01, 8'h01, 0); add(0, 8'h01, 8'h01, 0);
      add(0, 8'h01, 8'h01, 1); add(0, 8'h01, 8'h01, 0);
      add(1, 8'h00, 8'h00, 0);
      // Release hands over with no gap, then idle.
      add(0, 8'h82, 8'h02, 0); add(0, 8'h80, 8'h80, 0);
      add(0, 8'h00, 8'h00, 0); add(0, 8'h00, 8'h00, 0);
      // Full rotation with each holder dropping for one cycle.
      add(0, 8'hFF, 8'h01, 0); add(0, 8'hFE, 8'h02, 0);
      add(0, 8'hFD, 8'h04, 0); add(0, 8'hFB, 8'h08, 0);
      add(0, 8'hF7, 8'h10, 0); add(0, 8'hEF, 8'h20, 0);
      add(0, 8'hDF, 8'h40, 0); add(0, 8'hBF, 8'h80, 0);
      add(0, 8'h7F, 8'h01, 0); add(0, 8'h00, 8'h00, 0);
      // Two requesters alternate on timeout; no preemption in between.
      add(1, 8'h00, 8'h00, 0);
      add(0, 8'h05, 8'h01, 0); add(0, 8'h05, 8'h01, 0);
      add(0, 8'h05, 8'h01, 0); add(0, 8'h05, 8'h01, 0);
      add(0, 8'h05, 8'h04, 1); add(0, 8'h05, 8'h04, 0);
      add(0, 8'h05, 8'h04, 0); add(0, 8'h05, 8'h04, 0);
      add(0, 8'h05, 8'h01, 1); add(0, 8'h05, 8'h01, 0);
      add(0, 8'h00, 8'h00, 0);
      // Single requester: continuous grant, periodic timeout.
      add(0, 8'h08, 8'h08, 0); add(0, 8'h08, 8'h08, 0);
      add(0, 8'h08, 8'h08, 0); add(0, 8'h08, 8'h08, 0);
      add(0, 8'h08, 8'h08, 1); add(0, 8'h08, 8'h08, 0);
      add(0, 8'h08, 8'h08, 0); add(0, 8'h08, 8'h08, 0);
      add(0, 8'h08, 8'h08, 1);

      for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

      // Mid-grant reset restores the pointer so bit 0 wins first.
      v.rst = 0; v.req = 8'h10; v.exp_grant = 8'h10; v.exp_timeout = 0; apply(100, v);
      v.rst = 1; v.req = 8'hFF; v.exp_grant = 8'h00; v.exp_timeout = 0; apply(101, v);
      v.rst = 0; v.req = 8'hFF; v.exp_grant = 8'h01; v.exp_timeout = 0; apply(102, v);
      v.rst = 0; v.req = 8'hFE; v.exp_grant = 8'h02; v.exp_timeout = 0; apply(103, v);
      v.rst = 0; v.req = 8'h00; v.exp_grant = 8'h00; v.exp_timeout = 0; apply(104, v);

      n_checks++;
      if (sb.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: got %0d entries, expected 0", sb.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
